// File: rtl/ahb_slave_port_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ahb_slave_port_mux                                                |
// | Brief  : Grant-steered AHB slave port mux with data-phase ownership.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ahb_slave_port_mux #(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                         hclk,
  input  logic                         hreset_n,
  input  logic [MASTER_NUM*ADDR_W-1:0] m_haddr,
  input  logic [MASTER_NUM*2-1:0]      m_htrans,
  input  logic [MASTER_NUM-1:0]        m_hwrite,
  input  logic [MASTER_NUM*3-1:0]      m_hsize,
  input  logic [MASTER_NUM*3-1:0]      m_hburst,
  input  logic [MASTER_NUM*DATA_W-1:0] m_hwdata,
  input  logic [MASTER_NUM-1:0]        m_hreq,
  input  logic [MASTER_NUM-1:0]        hgrant,
  input  logic                         hsel_arb,
  input  logic                         s_hreadyout,
  input  logic                         s_hresp,
  input  logic [DATA_W-1:0]            s_hrdata,
  output logic                         s_hsel,
  output logic [ADDR_W-1:0]            s_haddr,
  output logic [1:0]                   s_htrans,
  output logic                         s_hwrite,
  output logic [2:0]                   s_hsize,
  output logic [2:0]                   s_hburst,
  output logic [DATA_W-1:0]            s_hwdata,
  output logic                         s_hready,
  output logic [MASTER_NUM-1:0]        m_hready,
  output logic [MASTER_NUM-1:0]        m_hresp,
  output logic [MASTER_NUM*DATA_W-1:0] m_hrdata,
  output logic                         hwait,
  output logic [2:0]                   hburst
);

  logic [MASTER_NUM-1:0] r_addr_own;
  logic [MASTER_NUM-1:0] r_data_own;
  logic [MASTER_NUM-1:0] w_addr_sel;
  logic                  w_grant_any;
  logic [ADDR_W-1:0]     w_haddr;
  logic [1:0]            w_htrans;
  logic                  w_hwrite;
  logic [2:0]            w_hsize;
  logic [2:0]            w_hburst;
  logic [DATA_W-1:0]     w_hwdata;

  assign w_grant_any = |hgrant;
  // A live grant wins; while the arbiter stalls, the registered owner keeps the bus.
  assign w_addr_sel  = w_grant_any ? hgrant : r_addr_own;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_addr_own <= '0;
    end else if (!hsel_arb) begin
      r_addr_own <= '0;
    end else if (w_grant_any) begin
      r_addr_own <= hgrant;
    end
  end

  // Only NONSEQ/SEQ advance to a data phase; IDLE and BUSY leave it unowned.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_data_own <= '0;
    end else if (s_hreadyout) begin
      r_data_own <= s_htrans[1] ? w_addr_sel : '0;
    end
  end

  always_comb begin
    w_haddr  = '0;
    w_htrans = '0;
    w_hwrite = 1'b0;
    w_hsize  = '0;
    w_hburst = '0;
    w_hwdata = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      w_haddr  = w_haddr  | (m_haddr[i*ADDR_W +: ADDR_W] & {ADDR_W{w_addr_sel[i]}});
      w_htrans = w_htrans | (m_htrans[i*2 +: 2]          & {2{w_addr_sel[i]}});
      w_hwrite = w_hwrite | (m_hwrite[i]                 & w_addr_sel[i]);
      w_hsize  = w_hsize  | (m_hsize[i*3 +: 3]           & {3{w_addr_sel[i]}});
      w_hburst = w_hburst | (m_hburst[i*3 +: 3]          & {3{w_addr_sel[i]}});
      w_hwdata = w_hwdata | (m_hwdata[i*DATA_W +: DATA_W] & {DATA_W{r_data_own[i]}});
    end
  end

  assign s_hsel   = hsel_arb & (|w_addr_sel);
  assign s_haddr  = w_haddr;
  assign s_htrans = w_htrans;
  assign s_hwrite = w_hwrite;
  assign s_hsize  = w_hsize;
  assign s_hburst = w_hburst;
  assign s_hwdata = w_hwdata;
  assign s_hready = s_hreadyout;
  assign hwait    = ~s_hreadyout;
  assign hburst   = w_hburst;
  assign m_hresp  = r_data_own & {MASTER_NUM{s_hresp}};

  generate
    for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_master
      logic w_req_xfer;
      assign w_req_xfer = m_hreq[gi] & m_htrans[gi*2+1];
      assign m_hrdata[gi*DATA_W +: DATA_W] = s_hrdata;
      // Owners see the slave's ready; a requesting non-owner is held off.
      assign m_hready[gi] = (r_data_own[gi] | w_addr_sel[gi]) ? s_hreadyout : ~w_req_xfer;
    end
  endgenerate

  a_grant_onehot : assert property (@(posedge hclk) disable iff (!hreset_n) $onehot0(hgrant));

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_port_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ahb_slave_port_mux                                             |
// | Brief  : Scoreboard bench with an index-level reference model.             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_ahb_slave_port_mux;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            hclk = 1'b0;
  logic            hreset_n;
  logic [N*AW-1:0] m_haddr;
  logic [N*2-1:0]  m_htrans;
  logic [N-1:0]    m_hwrite;
  logic [N*3-1:0]  m_hsize;
  logic [N*3-1:0]  m_hburst;
  logic [N*DW-1:0] m_hwdata;
  logic [N-1:0]    m_hreq;
  logic [N-1:0]    hgrant;
  logic            hsel_arb;
  logic            s_hreadyout;
  logic            s_hresp;
  logic [DW-1:0]   s_hrdata;
  logic            s_hsel;
  logic [AW-1:0]   s_haddr;
  logic [1:0]      s_htrans;
  logic            s_hwrite;
  logic [2:0]      s_hsize;
  logic [2:0]      s_hburst;
  logic [DW-1:0]   s_hwdata;
  logic            s_hready;
  logic [N-1:0]    m_hready;
  logic [N-1:0]    m_hresp;
  logic [N*DW-1:0] m_hrdata;
  logic            hwait;
  logic [2:0]      hburst;

  ahb_slave_port_mux #(.MASTER_NUM(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hburst(m_hburst), .m_hwdata(m_hwdata), .m_hreq(m_hreq),
    .hgrant(hgrant), .hsel_arb(hsel_arb),
    .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hwdata(s_hwdata), .s_hready(s_hready),
    .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
    .hwait(hwait), .hburst(hburst)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    int            cyc;
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [DW-1:0] hwdata;
    logic          sready;
    logic [N-1:0]  mready;
    logic [N-1:0]  mresp;
    logic [N*DW-1:0] mrdata;
    logic          hwait;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  // Model state: index of the address-phase and data-phase owners, -1 when none.
  int   own_a  = -1;
  int   own_d  = -1;

  function automatic int grant_idx(input logic [N-1:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic int cur_sel();
    int g = grant_idx(hgrant);
    return (g >= 0) ? g : own_a;
  endfunction

  task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    int   sel = cur_sel();
    e.cyc    = cyc;
    e.haddr  = '0; e.htrans = 2'd0; e.hwrite = 1'b0; e.hsize = '0; e.hburst = '0;
    if (sel >= 0) begin
      e.haddr  = m_haddr[sel*AW +: AW];
      e.htrans = m_htrans[sel*2 +: 2];
      e.hwrite = m_hwrite[sel];
      e.hsize  = m_hsize[sel*3 +: 3];
      e.hburst = m_hburst[sel*3 +: 3];
    end
    e.hsel   = hsel_arb && (sel >= 0);
    e.hwdata = (own_d >= 0) ? m_hwdata[own_d*DW +: DW] : '0;
    e.sready = s_hreadyout;
    e.hwait  = !s_hreadyout;
    e.mrdata = {N{s_hrdata}};
    for (int i = 0; i < N; i++) begin
      if (i == own_d || i == sel) e.mready[i] = s_hreadyout;
      else e.mready[i] = !(m_hreq[i] && m_htrans[i*2 +: 2] >= 2'd2);
      e.mresp[i] = (i == own_d) && s_hresp;
    end
    sbq.push_back(e);
  endtask

  task automatic model_clock();
    int g   = grant_idx(hgrant);
    int sel = cur_sel();
    if (!hreset_n) begin
      own_a = -1; own_d = -1;
      return;
    end
    if (s_hreadyout) own_d = (sel >= 0 && m_htrans[sel*2 +: 2] >= 2'd2) ? sel : -1;
    if (!hsel_arb) own_a = -1;
    else if (g >= 0) own_a = g;
  endtask

  // Push the expectation for the currently driven inputs, then advance one clock.
  task automatic issue();
    push_expected();
    @(posedge hclk);
    model_clock();
    cyc++;
    #1;
  endtask

  task automatic mset(input int i, input bit req, input bit [1:0] tr, input bit wr,
                      input bit [31:0] a, input bit [31:0] wd, input bit [2:0] bu);
    m_hreq[i]             = req;
    m_htrans[i*2 +: 2]    = tr;
    m_hwrite[i]           = wr;
    m_haddr[i*AW +: AW]   = a;
    m_hwdata[i*DW +: DW]  = wd;
    m_hsize[i*3 +: 3]     = 3'd2;
    m_hburst[i*3 +: 3]    = bu;
  endtask

  task automatic ctl(input bit [N-1:0] g, input bit sel, input bit rdy, input bit resp, input bit [31:0] rd);
    hgrant = g; hsel_arb = sel; s_hreadyout = rdy; s_hresp = resp; s_hrdata = rd;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("s_hsel",   e.cyc, 64'(s_hsel),   64'(e.hsel));
        chk("s_haddr",  e.cyc, 64'(s_haddr),  64'(e.haddr));
        chk("s_htrans", e.cyc, 64'(s_htrans), 64'(e.htrans));
        chk("s_hwrite", e.cyc, 64'(s_hwrite), 64'(e.hwrite));
        chk("s_hsize",  e.cyc, 64'(s_hsize),  64'(e.hsize));
        chk("s_hburst", e.cyc, 64'(s_hburst), 64'(e.hburst));
        chk("hburst",   e.cyc, 64'(hburst),   64'(e.hburst));
        chk("s_hwdata", e.cyc, 64'(s_hwdata), 64'(e.hwdata));
        chk("s_hready", e.cyc, 64'(s_hready), 64'(e.sready));
        chk("hwait",    e.cyc, 64'(hwait),    64'(e.hwait));
        chk("m_hready", e.cyc, 64'(m_hready), 64'(e.mready));
        chk("m_hresp",  e.cyc, 64'(m_hresp),  64'(e.mresp));
        chk("m_hrdata", e.cyc, 64'(m_hrdata), 64'(e.mrdata));
      end
    end
  end

  initial begin
    hreset_n = 1'b0;
    m_haddr = '0; m_htrans = '0; m_hwrite = '0; m_hsize = '0; m_hburst = '0;
    m_hwdata = '0; m_hreq = '0;
    ctl(2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge hclk); #1;

    // Reset state, with M1 requesting so the un-granted stall is visible.
    mset(1, 1, 2'd2, 0, 32'h200, 32'h0, 3'd0);
    ctl(2'b00, 1'b0, 1'b1, 1'b1, 32'h1111_0000);
    issue(); issue();
    hreset_n = 1'b1;
    mset(1, 0, 2'd0, 0, 32'h0, 32'h0, 3'd0);
    issue();

    // Single write from M0, then handover to an M1 read.
    mset(0, 1, 2'd2, 1, 32'h100, 32'h0, 3'd0);
    ctl(2'b01, 1'b1, 1'b1, 1'b0, 32'h0);
    issue();
    mset(0, 0, 2'd0, 0, 32'h0, 32'hA5A5_0001, 3'd0);
    mset(1, 1, 2'd2, 0, 32'h200, 32'h0, 3'd0);
    ctl(2'b10, 1'b1, 1'b1, 1'b0, 32'h0);
    issue();
    mset(1, 0, 2'd0, 0, 32'h0, 32'h0, 3'd0);
    ctl(2'b00, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    issue();

    // INCR4 with two wait states while the arbiter stalls; M1 contends meanwhile.
    mset(0, 1, 2'd2, 1, 32'h300, 32'h0, 3'd3);
    ctl(2'b01, 1'b1, 1'b1, 1'b0, 32'h0);
    issue();
    mset(0, 1, 2'd3, 1, 32'h304, 32'hC0DE_0000, 3'd3);
    mset(1, 1, 2'd2, 0, 32'h400, 32'h0, 3'd0);
    ctl(2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(); issue();
    ctl(2'b01, 1'b1, 1'b1, 1'b0, 32'h0);
    issue();
    mset(0, 0, 2'd0, 0, 32'h0, 32'hC0DE_0001, 3'd0);
    ctl(2'b10, 1'b1, 1'b1, 1'b0, 32'h0);
    issue();

    // Two-cycle ERROR to M1.
    mset(1, 0, 2'd0, 0, 32'h0, 32'h0, 3'd0);
    ctl(2'b00, 1'b1, 1'b0, 1'b1, 32'h0);
    issue();
    ctl(2'b00, 1'b1, 1'b1, 1'b1, 32'h0);
    issue();
    ctl(2'b00, 1'b1, 1'b1, 1'b0, 32'h0);
    issue();

    // Reset during an M0 SEQ beat; the arbiter resets alongside and drops its grant.
    mset(0, 1, 2'd2, 1, 32'h500, 32'h0, 3'd1);
    ctl(2'b01, 1'b1, 1'b1, 1'b0, 32'h0);
    issue();
    mset(0, 1, 2'd3, 1, 32'h504, 32'h7777_0000, 3'd1);
    issue();
    hreset_n = 1'b0; own_a = -1; own_d = -1;
    ctl(2'b00, 1'b1, 1'b0, 1'b1, 32'h0);
    issue();
    hreset_n = 1'b1;
    mset(0, 0, 2'd0, 0, 32'h0, 32'h0, 3'd0);
    ctl(2'b00, 1'b1, 1'b1, 1'b1, 32'h0);
    issue();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        mset(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) hgrant = '0;
      else hgrant = N'(1) << $urandom_range(0, N-1);
      hsel_arb    = ($urandom_range(0, 9) != 0);
      s_hreadyout = ($urandom_range(0, 3) != 0);
      s_hresp     = ($urandom_range(0, 6) == 0);
      s_hrdata    = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        hreset_n = 1'b0; own_a = -1; own_d = -1;
      end else begin
        hreset_n = 1'b1;
      end
      issue();
    end

    @(negedge hclk); #1;
    chk("scoreboard_drain", cyc, 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_slave_port_mux.md
# ahb_slave_port_mux

Slave-side routing stage placed directly downstream of a per-slave AHB arbiter. It uses the arbiter's one-hot grant to steer the owning master's address-phase signals onto one slave port. It tracks data-phase ownership so write data and the slave's response are routed to the correct master. It also generates the `hwait` and `hburst` feedback the arbiter consumes.

## Interface
- `MASTER_NUM`, 2: number of masters competing for this slave (≥1).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `hclk`  in  1  clock.
- `hreset_n`  in  1  reset; asynchronous, active-low.
- `m_haddr`  in  MASTER_NUM×ADDR_W  per-master address.
- `m_htrans`  in  MASTER_NUM×2  per-master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `m_hwrite`  in  MASTER_NUM  per-master write flag.
- `m_hsize`  in  MASTER_NUM×3  per-master size.
- `m_hburst`  in  MASTER_NUM×3  per-master burst type.
- `m_hwdata`  in  MASTER_NUM×DATA_W  per-master write data.
- `m_hreq`  in  MASTER_NUM  per-master request toward this slave (same vector the arbiter sees).
- `hgrant`  in  MASTER_NUM  one-hot address-phase grant from the arbiter; all-zero while the arbiter stalls.
- `hsel_arb`  in  1  arbiter slave-select.
- `s_hreadyout`  in  1  slave ready.
- `s_hresp`  in  1  slave response (0 OKAY, 1 ERROR).
- `s_hrdata`  in  DATA_W  slave read data.
- `s_hsel`, `s_haddr`, `s_htrans`, `s_hwrite`, `s_hsize`, `s_hburst`, `s_hwdata`  out  1/ADDR_W/2/1/3/3/DATA_W  muxed slave port.
- `s_hready`  out  1  HREADY driven to the slave; equals `s_hreadyout`.
- `m_hready`  out  MASTER_NUM  per-master HREADY.
- `m_hresp`  out  MASTER_NUM  per-master response.
- `m_hrdata`  out  MASTER_NUM×DATA_W  per-master read data (broadcast).
- `hwait`  out  1  to arbiter; `= ~s_hreadyout`.
- `hburst`  out  3  to arbiter; `= s_hburst`.

## Operation
- **addr_own register** (MASTER_NUM, one-hot or zero).
  - Loads `hgrant` whenever `hgrant != 0`.
  - Holds while `hgrant == 0` (arbiter stalled on `hwait`).
  - Clears when `hsel_arb == 0`.
- **Address mux.** `s_haddr`, `s_hwrite`, `s_hsize`, `s_hburst` and `s_htrans` are AND-OR muxed by `addr_sel`.
  - `addr_sel = hgrant` if nonzero, else `addr_own`.
  - `s_hsel = hsel_arb & |addr_sel`.
  - When `addr_sel == 0`: `s_htrans = IDLE` and all other address outputs are 0.
- **data_own register** (MASTER_NUM).
  - On a cycle with `s_hreadyout == 1`, loads `addr_sel` if `s_htrans[1] == 1` (NONSEQ/SEQ); otherwise loads 0.
  - Holds while `s_hreadyout == 0`.
- **Data routing.**
  - `s_hwdata` is muxed by `data_own`; it is 0 when `data_own == 0`.
  - `m_hrdata[i] = s_hrdata` for all i.
  - `m_hresp[i] = data_own[i] & s_hresp`.
- **Per-master HREADY**, evaluated in priority order:
  1. `data_own[i]`: `m_hready[i] = s_hreadyout`.
  2. Otherwise, `addr_sel[i]`: `m_hready[i] = s_hreadyout`.
  3. Otherwise, if `m_hreq[i]` and `m_htrans[i]` is NONSEQ/SEQ: `m_hready[i] = 0` (stall un-granted master).
  4. Otherwise: `m_hready[i] = 1`.
- **ERROR.** The two-cycle response is passed through unchanged. If the owner drives IDLE in the second cycle, `data_own` clears on that cycle's ready.
- **Invalid grant.** A multi-hot `hgrant` is illegal; an assertion flags it. The RTL's behaviour in that case is undefined.

## Timing
- Address path is combinational from `m_*`/`hgrant` to `s_*`. There is zero added latency in the address phase.
- Data phase owner is valid one cycle after the accepted address phase.
- Reset values:
  - `addr_own = 0`, `data_own = 0`.
  - Hence `s_hsel = 0`, `s_htrans = IDLE`, `s_hwdata = 0`, `m_hresp = 0`.
  - `m_hready` = all 1 unless a master requests (rule 3).
  - `hwait` follows the slave.
- Wait states: `addr_own` and `data_own` freeze, so address and control stay stable on `s_*` for the whole wait.
- Handover from A to B: in the same cycle, B owns the address phase while A owns the data phase. `s_hwdata` comes from A and B's address is on `s_haddr`.
- Reset asserted mid-transfer clears both registers immediately. No response is routed after reset.
- BUSY is not an address transfer, so `data_own` loads 0 after a BUSY cycle.

## Test plan
- **Single write.** Stimulus: M0 requests; `hgrant = 01`, NONSEQ write to 0x100, `hwdata` = 0xA5A5_0001, slave ready. Response: `s_haddr` = 0x100 in cycle 0; `s_hwdata` = 0xA5A5_0001 in cycle 1; `m_hready[1] = 1` throughout.
- **Back-to-back handover.** Stimulus: M0 single write, then the next cycle `hgrant = 10` with an M1 read. Response: in that cycle `s_haddr` = M1's address and `s_hwdata` = M0's data; in the following cycle M1 receives `s_hrdata` and `data_own = 10`.
- **Wait states.** Stimulus: `s_hreadyout` low for 2 cycles during an M0 INCR4, and the arbiter drives `hgrant = 0`. Response: `s_haddr`/`s_htrans` held; `hwait = 1`; `m_hready[0] = 0` for both cycles; `data_own` unchanged.
- **Contention stall.** Stimulus: M1 requests NONSEQ while `hgrant = 01`. Response: `m_hready[1] = 0` until `hgrant = 10`.
- **ERROR response.** Stimulus: slave returns a two-cycle ERROR to M1. Response: `m_hresp = 10` both cycles; `m_hready[1]` = 0 then 1; `m_hresp[0] = 0`.
- **Reset mid-burst.** Stimulus: assert `hreset_n` low during an M0 SEQ beat. Response: `s_hsel = 0`, `s_htrans = IDLE` and `data_own = 0` immediately, without waiting for a clock edge.
